oled_glyph_streamer: RTL and testbench
======================================

# oled_glyph_streamer

Parametrised glyph source for the OLED text path. Accepts one glyph request at a time and streams its column bytes from an internal font ROM over a valid/ready byte interface to the OLED page writer. Supports narrow (8-column) and wide (16-column) glyphs, single-page or two-page streaming, optional bit inversion, and back-pressure at full byte rate. Invalid glyph codes raise an error flag.

## Interface
- GLYPH_CNT, 16, number of glyphs in the ROM (codes 0..GLYPH_CNT-1)
- NARROW_W, 8, columns per page for narrow glyphs
- WIDE_W, 16, columns per page for wide glyphs
- SEL_W, $clog2(GLYPH_CNT), glyph code width
- sys_clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  glyph request present
- req_ready  out  1  block idle; request accepted on req_valid && req_ready
- req_glyph  in  SEL_W  glyph code
- req_page  in  1  start page: 0 = top, 1 = bottom
- req_both  in  1  stream the top page, then the bottom page (req_page ignored)
- req_invert  in  1  output bytes bitwise inverted
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  column byte, LSB = top pixel row of the page
- out_col  out  5  column index within the current page
- out_page_end  out  1  last byte of a page
- out_last  out  1  last byte of the request
- busy  out  1  request in progress, including the final byte until it is accepted
- err_pulse  out  1  one-cycle pulse: code >= GLYPH_CNT

## Operation
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: req_ready = 1.
  - Accept with a valid code: latch glyph, page, both, invert; load col = 0; go to STREAM.
  - Accept with an invalid code: pulse err_pulse in the next cycle, stream nothing, stay in IDLE. req_ready stays high.
- Glyph width comes from a per-code width table: W = NARROW_W or WIDE_W.
- ROM address = base[glyph] + page*W + col. The ROM has a synchronous 1-cycle read.
- Advance enable: adv = !out_valid || out_ready.
  - On adv in STREAM, the ROM output register loads, out_valid is set, and col increments.
  - At col = W-1: if req_both and page = 0, go to page 1 with col = 0; otherwise go to DRAIN.
- DRAIN: hold until the final byte is accepted (out_valid && out_ready && out_last), then go to IDLE with out_valid = 0.
- out_col, out_page_end and out_last are pipelined with out_data and describe the byte currently presented.
- out_data = ROM byte ^ {8{invert}}.
- While out_valid && !out_ready, every out_* signal stays stable.

## Timing
- Reset values:
  - req_ready = 1
  - out_valid = 0
  - out_data = 0x00
  - out_col = 0
  - out_page_end = 0
  - out_last = 0
  - busy = 0
  - err_pulse = 0
  - FSM = IDLE
- Latency: request accepted at edge T; first out_valid is high after edge T+2.
- Throughput: 1 byte per cycle while out_ready = 1.
- Byte count per request: W, or 2W when req_both = 1.
- Back-to-back requests: the next request can be accepted in the cycle after the out_last handshake.
- Reset mid-stream: immediate return to reset values; the partial glyph is discarded and no out_last is produced.
- out_ready may drop on any cycle, including the out_last cycle; no byte may be lost or duplicated.

## Structure
- Package oled_font_pkg holds:
  - GLYPH_CNT
  - NARROW_W and WIDE_W
  - the width table (per code: narrow or wide)
  - the base-offset table
  - the ROM depth
- Sub-module oled_font_rom: synchronous ROM with ports clk, en, addr, dout.
  - Flat byte array initialised from package constants.
  - Register with enable = adv.
- Top level contains the FSM, the address and column counters, and the pipelined tag bits.

## Test plan
- Narrow glyph 12, top page, out_ready = 1: bytes 08 F8 88 88 88 88 70 00; out_col 0..7; out_last on byte 7; first out_valid at T+2.
- Same glyph with req_both = 1 and req_invert = 1: 16 bytes; byte 0 = F7, byte 8 = DF; out_page_end on bytes 7 and 15; out_last only on byte 15.
- Wide glyph 3, bottom page, with out_ready toggling 1/0 every cycle: 16 bytes 08 08 09 09 09 09 09 FF 09 09 09 09 09 08 08 00 with no loss or duplication, and outputs stable while stalled.
- req_glyph = GLYPH_CNT: err_pulse high for exactly 1 cycle; out_valid never asserts; req_ready stays 1.
- rst asserted on byte 5 of a wide glyph: outputs return to reset values immediately; a new request for glyph 0 afterwards streams correctly from col 0.
- Two requests back-to-back with out_ready = 1: the second is accepted the cycle after the first out_last; no idle gap is required beyond the 2-cycle latency.

Source files
------------

// File: rtl/oled_font_pkg.sv
// Font constants for the OLED glyph streamer: glyph geometry, width/base tables,
// FSM encoding and the flattened ROM image built from the per-glyph column bytes.
package oled_font_pkg;

    localparam int GLYPH_CNT = 16;
    localparam int NARROW_W  = 8;
    localparam int WIDE_W    = 16;
    localparam int CODE_W    = $clog2(GLYPH_CNT);

    // Codes 0..3 are wide, the rest narrow; every glyph stores two pages.
    localparam logic [GLYPH_CNT-1:0] WIDE_TAB = 16'h000f;
    localparam int BASE_TAB [GLYPH_CNT] = '{
        0, 32, 64, 96, 128, 144, 160, 176,
        192, 208, 224, 240, 256, 272, 288, 304
    };
    localparam int ROM_DEPTH = 320;
    localparam int ROM_AW    = $clog2(ROM_DEPTH);
    localparam int ROM_SLOTS = 1 << ROM_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    function automatic int glyph_w(input int g);
        return WIDE_TAB[g[CODE_W-1:0]] ? WIDE_W : NARROW_W;
    endfunction

    // Column byte of glyph g, page p, column c (LSB = top pixel row of the page).
    function automatic logic [7:0] glyph_col_byte(input int g, input int p, input int c);
        logic [7:0] b;
        b = 8'(g * 37 + p * 91 + c * 13) ^ 8'h5a;
        if (g == 12 && p == 0) begin
            case (c)
                0:       b = 8'h08;
                1:       b = 8'hf8;
                6:       b = 8'h70;
                7:       b = 8'h00;
                default: b = 8'h88;
            endcase
        end else if (g == 12) begin
            case (c)
                0:       b = 8'h20;
                1:       b = 8'h3f;
                6:       b = 8'h1f;
                7:       b = 8'h00;
                default: b = 8'h20;
            endcase
        end else if (g == 3 && p == 1) begin
            case (c)
                0, 1, 13, 14: b = 8'h08;
                7:            b = 8'hff;
                15:           b = 8'h00;
                default:      b = 8'h09;
            endcase
        end
        return b;
    endfunction

    function automatic logic [ROM_SLOTS*8-1:0] build_font();
        logic [ROM_SLOTS*8-1:0] f;
        int a;
        f = '0;
        for (int g = 0; g < GLYPH_CNT; g++) begin
            for (int p = 0; p < 2; p++) begin
                for (int c = 0; c < glyph_w(g); c++) begin
                    a = BASE_TAB[g[CODE_W-1:0]] + p * glyph_w(g) + c;
                    f[a*8 +: 8] = glyph_col_byte(g, p, c);
                end
            end
        end
        return f;
    endfunction

    localparam logic [ROM_SLOTS*8-1:0] FONT_FLAT = build_font();

endpackage

// File: rtl/oled_font_rom.sv
// Synchronous font ROM: one registered byte read per enabled cycle.
module oled_font_rom
    import oled_font_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr,
    output logic [7:0]        dout
);

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= FONT_FLAT[{addr, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/oled_glyph_streamer.sv
// Streams the column bytes of one glyph request from the font ROM to the OLED
// page writer, with a two-stage (ROM, output) pipeline stalled as a unit.
module oled_glyph_streamer
    import oled_font_pkg::*;
#(
    parameter int SEL_W = $clog2(GLYPH_CNT)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_glyph,
    input  logic             req_page,
    input  logic             req_both,
    input  logic             req_invert,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [4:0]       out_col,
    output logic             out_page_end,
    output logic             out_last,
    output logic             busy,
    output logic             err_pulse,
    output state_t           dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid && ready; a
    // source holding valid keeps its payload stable until that edge.
    state_t            state;
    logic [ROM_AW-1:0] base_q;
    logic              wide_q, page_q, both_q, inv_q;
    logic [3:0]        col_q;
    logic              s1_valid, s1_page_end, s1_last;
    logic [3:0]        s1_col;
    logic [7:0]        rom_dout;

    logic              accept, code_ok, adv, col_end, page_more;
    logic [CODE_W-1:0] code_idx;
    logic [ROM_AW-1:0] page_off, rom_addr;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign accept    = req_valid && req_ready;
    assign code_ok   = 32'(req_glyph) < 32'(GLYPH_CNT);
    assign code_idx  = req_glyph[CODE_W-1:0];
    assign adv       = !out_valid || out_ready;
    assign col_end   = col_q == (wide_q ? 4'(WIDE_W - 1) : 4'(NARROW_W - 1));
    assign page_more = both_q && !page_q;
    assign page_off  = page_q ? (wide_q ? ROM_AW'(WIDE_W) : ROM_AW'(NARROW_W)) : '0;
    assign rom_addr  = base_q + page_off + ROM_AW'(col_q);

    oled_font_rom u_rom (
        .clk  (sys_clk),
        .en   (adv),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            base_q       <= '0;
            wide_q       <= 1'b0;
            page_q       <= 1'b0;
            both_q       <= 1'b0;
            inv_q        <= 1'b0;
            col_q        <= '0;
            s1_valid     <= 1'b0;
            s1_col       <= '0;
            s1_page_end  <= 1'b0;
            s1_last      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            out_col      <= '0;
            out_page_end <= 1'b0;
            out_last     <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            err_pulse <= accept && !code_ok;

            // Output stage takes whatever the ROM stage holds; tags ride along.
            if (adv) begin
                out_valid <= s1_valid;
                s1_valid  <= 1'b0;
                if (s1_valid) begin
                    out_data     <= rom_dout ^ {8{inv_q}};
                    out_col      <= {1'b0, s1_col};
                    out_page_end <= s1_page_end;
                    out_last     <= s1_last;
                end
            end

            case (state)
                IDLE: begin
                    if (accept && code_ok) begin
                        base_q <= ROM_AW'(BASE_TAB[code_idx]);
                        wide_q <= WIDE_TAB[code_idx];
                        page_q <= req_both ? 1'b0 : req_page;
                        both_q <= req_both;
                        inv_q  <= req_invert;
                        col_q  <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (adv) begin
                        s1_valid    <= 1'b1;
                        s1_col      <= col_q;
                        s1_page_end <= col_end;
                        s1_last     <= col_end && !page_more;
                        if (!col_end) begin
                            col_q <= col_q + 4'd1;
                        end else if (page_more) begin
                            page_q <= 1'b1;
                            col_q  <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_glyph_streamer.sv
// Bench for oled_glyph_streamer: directed font vectors plus randomized requests
// against a queue-based model of the byte stream.
module tb_oled_glyph_streamer;

    localparam int SEL_W = 5;

    logic             sys_clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [SEL_W-1:0] req_glyph = '0;
    logic             req_page = 1'b0;
    logic             req_both = 1'b0;
    logic             req_invert = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic [4:0]       out_col;
    logic             out_page_end;
    logic             out_last;
    logic             busy;
    logic             err_pulse;
    oled_font_pkg::state_t dbg_state;

    oled_glyph_streamer #(.SEL_W(SEL_W)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_glyph    (req_glyph),
        .req_page     (req_page),
        .req_both     (req_both),
        .req_invert   (req_invert),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col      (out_col),
        .out_page_end (out_page_end),
        .out_last     (out_last),
        .busy         (busy),
        .err_pulse    (err_pulse),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [14:0] exp_q[$];   // {last, page_end, col[4:0], data[7:0]}
    int exp_err  = 0;
    int err_seen = 0;
    int n_got    = 0;
    int last_hs_edge = -1;
    int rdy_mode = 0;        // 0: always ready, 1: toggle, 2: random

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic [15:0] prev_snap = '0;
    logic [14:0] exp_word;

    always @(negedge sys_clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_eq("stall_hold", 32'({out_valid, out_last, out_page_end, out_col, out_data}),
                         32'(prev_snap));
            if (err_pulse) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_byte", 32'(exp_q.size()), 1);
                end else begin
                    exp_word = exp_q.pop_front();
                    check_eq("byte", 32'({out_last, out_page_end, out_col, out_data}), 32'(exp_word));
                end
                n_got++;
                if (out_last) last_hs_edge = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = {out_valid, out_last, out_page_end, out_col, out_data};
        end
    end

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int model_w(input int g);
        return (g < 4) ? 16 : 8;
    endfunction

    task automatic push_entry(input logic [7:0] d, input int col, input bit pe, input bit last);
        exp_q.push_back({last, pe, 5'(col), d});
    endtask

    task automatic expect_glyph(input int g, input bit page, input bit both, input bit inv);
        int w, p0, p1;
        logic [7:0] d;
        w  = model_w(g);
        p0 = both ? 0 : int'(page);
        p1 = both ? 1 : int'(page);
        for (int p = p0; p <= p1; p++) begin
            for (int c = 0; c < w; c++) begin
                d = oled_font_pkg::glyph_col_byte(g, p, c) ^ (inv ? 8'hff : 8'h00);
                push_entry(d, c, c == w - 1, (p == p1) && (c == w - 1));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_req(input int g, input bit page, input bit both, input bit inv,
                            input bit lat_chk, output int acc_edge);
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_glyph  = SEL_W'(g);
        req_page   = page;
        req_both   = both;
        req_invert = inv;
        @(posedge sys_clk); #1;
        acc_edge  = cyc;
        req_valid = 1'b0;
        if (lat_chk) begin
            check_eq("lat_t0_valid", 32'(out_valid), 0);
            check_eq("lat_t0_busy", 32'(busy), 1);
            @(posedge sys_clk); #1;
            check_eq("lat_t1_valid", 32'(out_valid), 0);
            @(posedge sys_clk); #1;
            check_eq("lat_t2_valid", 32'(out_valid), 1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check_eq("drain_queue", 32'(exp_q.size()), 0);
        check_eq("drain_busy", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_data"}, 32'(out_data), 0);
        check_eq({tag, "_out_col"}, 32'(out_col), 0);
        check_eq({tag, "_page_end"}, 32'(out_page_end), 0);
        check_eq({tag, "_out_last"}, 32'(out_last), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_err_pulse"}, 32'(err_pulse), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] g12_top [8]  = '{8'h08, 8'hf8, 8'h88, 8'h88, 8'h88, 8'h88, 8'h70, 8'h00};
    logic [7:0] g3_bot  [16] = '{8'h08, 8'h08, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'hff,
                                 8'h09, 8'h09, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h00};

    initial begin
        int acc, acc2, first_last, n, g;
        bit pg, bo, iv;

        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(posedge sys_clk); #1;
        check_reset_outputs("rst_rel");

        // Narrow glyph 12, top page, full rate.
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) push_entry(g12_top[i], i, i == 7, i == 7);
        send_req(12, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        wait_done();

        // Same glyph, both pages, inverted.
        for (int i = 0; i < 8; i++) push_entry(~g12_top[i], i, i == 7, 1'b0);
        push_entry(8'hdf, 0, 1'b0, 1'b0);
        for (int c = 1; c < 8; c++)
            push_entry(~oled_font_pkg::glyph_col_byte(12, 1, c), c, c == 7, c == 7);
        send_req(12, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        wait_done();

        // Wide glyph 3, bottom page, ready toggling every cycle.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) push_entry(g3_bot[i], i, i == 15, i == 15);
        send_req(3, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        wait_done();

        // Invalid code.
        rdy_mode = 0;
        exp_err++;
        send_req(16, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check_eq("err_pulse_hi", 32'(err_pulse), 1);
        check_eq("err_req_ready", 32'(req_ready), 1);
        @(posedge sys_clk); #1;
        check_eq("err_pulse_lo", 32'(err_pulse), 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("err_no_valid", 32'(out_valid), 0);
            check_eq("err_ready_hold", 32'(req_ready), 1);
            @(posedge sys_clk); #1;
        end

        // Reset while byte 5 of a wide glyph is presented.
        n_got = 0;
        expect_glyph(1, 1'b0, 1'b0, 1'b0);
        send_req(1, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        n = 0;
        while (!(out_valid && out_col == 5'd5) && n < 100) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check_eq("rst_reach_byte5", 32'(out_col), 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        check_eq("rst_bytes_before", 32'(n_got), 5);
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        @(posedge sys_clk); #1;
        check_reset_outputs("rst_after");
        expect_glyph(0, 1'b0, 1'b0, 1'b0);
        send_req(0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        wait_done();

        // Back-to-back requests at full rate.
        expect_glyph(12, 1'b0, 1'b0, 1'b0);
        expect_glyph(5, 1'b1, 1'b0, 1'b1);
        send_req(12, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        send_req(5, 1'b1, 1'b0, 1'b1, 1'b1, acc2);
        first_last = last_hs_edge;
        check_eq("b2b_accept_edge", 32'(acc2), 32'(first_last + 1));
        wait_done();

        // Randomized requests and back-pressure.
        for (int i = 0; i < 40; i++) begin
            rdy_mode = $urandom_range(0, 2);
            g  = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
            pg = 1'($urandom_range(0, 1));
            bo = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 1));
            if (g < 16) expect_glyph(g, pg, bo, iv);
            else exp_err++;
            send_req(g, pg, bo, iv, g < 16, acc);
        end
        wait_done();
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("err_pulse_count", 32'(err_seen), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
